// File: rtl/sparse_row_streamer_if.sv
// Handshake bundle between the fetch logic, the sparse row streamer and the accumulator.
// With SRS_UNDERRUN_CNT_EN defined the bundle also carries the starvation counter.
interface sparse_row_streamer_if #(
    parameter int DATA_W = 24,
    parameter int NZE_W  = 4,
    parameter int ROWS_W = 8
);
    logic              start;
    logic [ROWS_W-1:0] num_rows;
    logic              nze_valid;
    logic [NZE_W-1:0]  row_nze;
    logic              nze_ready;
    logic              val_valid;
    logic [DATA_W-1:0] val_data;
    logic              val_ready;
    logic [DATA_W:0]   element;
    logic              set_bit;
    logic [ROWS_W-1:0] row_index;
    logic              busy;
    logic              done;
    logic              underrun;
`ifdef SRS_UNDERRUN_CNT_EN
    logic [7:0]        underrun_cnt;
`endif

    modport master (
        input  start, num_rows, nze_valid, row_nze, val_valid, val_data,
        output nze_ready, val_ready, element, set_bit, row_index, busy, done, underrun
`ifdef SRS_UNDERRUN_CNT_EN
        , output underrun_cnt
`endif
    );

    modport slave (
        output start, num_rows, nze_valid, row_nze, val_valid, val_data,
        input  nze_ready, val_ready, element, set_bit, row_index, busy, done, underrun
`ifdef SRS_UNDERRUN_CNT_EN
        , input underrun_cnt
`endif
    );
endinterface

// File: rtl/sparse_row_streamer.sv
// Turns per-row NZE counts plus a value stream into the marked element stream, with drain bubbles per row.
// Define SRS_UNDERRUN_CNT_EN to add the saturating starvation-cycle counter underrun_cnt.
module sparse_row_streamer #(
    parameter int DATA_W       = 24,
    parameter int NZE_W        = 4,
    parameter int ROWS_W       = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    sparse_row_streamer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, STREAM, DRAIN, DONE} state_t;

    state_t            state_reg;
    logic [ROWS_W-1:0] num_rows_reg;
    logic [ROWS_W-1:0] row_index_reg;
    logic [NZE_W-1:0]  remaining_reg;
    logic              first_reg;
    logic [3:0]        drain_reg;
    logic [DATA_W:0]   element_reg;
    logic              set_bit_reg;
    logic              done_reg;
    logic              underrun_reg;
`ifdef SRS_UNDERRUN_CNT_EN
    logic [7:0]        underrun_cnt_reg;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            num_rows_reg     <= '0;
            row_index_reg    <= '0;
            remaining_reg    <= '0;
            first_reg        <= 1'b0;
            drain_reg        <= '0;
            element_reg      <= '0;
            set_bit_reg      <= 1'b0;
            done_reg         <= 1'b0;
            underrun_reg     <= 1'b0;
`ifdef SRS_UNDERRUN_CNT_EN
            underrun_cnt_reg <= '0;
`endif
        end else begin
            // Every cycle is a bubble unless a state below emits something.
            element_reg <= '0;
            set_bit_reg <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
`ifdef SRS_UNDERRUN_CNT_EN
                        underrun_cnt_reg <= '0;
`endif
                        if (bus.num_rows != '0) begin
                            num_rows_reg  <= bus.num_rows;
                            row_index_reg <= '0;
                            underrun_reg  <= 1'b0;
                            state_reg     <= FETCH;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (bus.nze_valid) begin
                        remaining_reg <= bus.row_nze;
                        if (bus.row_nze != '0) begin
                            first_reg <= 1'b1;
                            state_reg <= STREAM;
                        end else begin
                            // Empty row still needs a marker so the accumulator closes it.
                            element_reg <= {1'b1, {DATA_W{1'b0}}};
                            set_bit_reg <= 1'b1;
                            drain_reg   <= '0;
                            state_reg   <= DRAIN;
                        end
                    end
                end
                STREAM: begin
                    if (bus.val_valid) begin
                        element_reg   <= {remaining_reg == NZE_W'(1), bus.val_data};
                        set_bit_reg   <= first_reg;
                        first_reg     <= 1'b0;
                        remaining_reg <= remaining_reg - 1'b1;
                        if (remaining_reg == NZE_W'(1)) begin
                            drain_reg <= '0;
                            state_reg <= DRAIN;
                        end
                    end else begin
                        underrun_reg <= 1'b1;
`ifdef SRS_UNDERRUN_CNT_EN
                        if (underrun_cnt_reg != 8'hFF)
                            underrun_cnt_reg <= underrun_cnt_reg + 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    if (drain_reg == 4'(DRAIN_CYCLES - 1)) begin
                        if (row_index_reg == num_rows_reg - 1'b1) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            row_index_reg <= row_index_reg + 1'b1;
                            state_reg     <= FETCH;
                        end
                    end else begin
                        drain_reg <= drain_reg + 1'b1;
                    end
                end
                DONE: begin
                    row_index_reg <= '0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Readies depend on the state register only, never on the partner's valid.
    assign bus.nze_ready = (state_reg == FETCH);
    assign bus.val_ready = (state_reg == STREAM);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.element   = element_reg;
    assign bus.set_bit   = set_bit_reg;
    assign bus.row_index = row_index_reg;
    assign bus.done      = done_reg;
    assign bus.underrun  = underrun_reg;
`ifdef SRS_UNDERRUN_CNT_EN
    assign bus.underrun_cnt = underrun_cnt_reg;
`endif
endmodule

// File: tb/tb_sparse_row_streamer.sv
// Scoreboard bench: passes are queued as NZE/value streams, expected elements are derived per row,
// and a monitor pops and compares every non-bubble element the streamer emits.
module tb_sparse_row_streamer;
    localparam int DATA_W       = 24;
    localparam int NZE_W        = 4;
    localparam int ROWS_W       = 8;
    localparam int DRAIN_CYCLES = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sparse_row_streamer_if #(.DATA_W(DATA_W), .NZE_W(NZE_W), .ROWS_W(ROWS_W)) bus ();

    sparse_row_streamer #(
        .DATA_W(DATA_W), .NZE_W(NZE_W), .ROWS_W(ROWS_W), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    typedef struct {
        logic [DATA_W:0]   el;
        logic              sb;
        logic [ROWS_W-1:0] ri;
    } exp_t;

    exp_t              exp_q[$];
    logic [NZE_W-1:0]  nze_q[$];
    logic [DATA_W-1:0] val_q[$];
    exp_t              mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = -1, last_cyc = -1, first_cyc = -1, gap = -1, sb_cnt = 0;
    bit saw_val_ready = 0, saw_nze_ready = 0;
    bit rand_stall = 0, val_hold = 0;
    int drop_after = 0, drop_left = 0, val_accepted = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (bus.val_ready) saw_val_ready = 1;
            if (bus.nze_ready) saw_nze_ready = 1;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.element != '0 || bus.set_bit) begin
                if (bus.set_bit) begin
                    sb_cnt++;
                    first_cyc = cyc;
                    if (last_cyc >= 0) gap = cyc - last_cyc - 1;
                end
                $display("elem cyc=%0d row=%0d set_bit=%b element=%h", cyc, bus.row_index, bus.set_bit, bus.element);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_element actual=%h required=none", bus.element);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("element", 64'(bus.element), 64'(mon_e.el));
                    check("set_bit", 64'(bus.set_bit), 64'(mon_e.sb));
                    check("row_index", 64'(bus.row_index), 64'(mon_e.ri));
                end
                if (bus.element[DATA_W]) last_cyc = cyc;
            end
        end
    end

    // NZE producer.
    initial begin
        bus.nze_valid = 1'b0;
        bus.row_nze   = '0;
        forever begin
            @(negedge clock);
            bus.nze_valid = 1'b0;
            if (nze_q.size() > 0 && !(rand_stall && $urandom_range(3) == 0)) begin
                bus.nze_valid = 1'b1;
                bus.row_nze   = nze_q[0];
                if (bus.nze_ready) void'(nze_q.pop_front());
            end
        end
    end

    // Value producer with optional directed drop and random stalls.
    initial begin
        bus.val_valid = 1'b0;
        bus.val_data  = '0;
        forever begin
            @(negedge clock);
            bus.val_valid = 1'b0;
            if (drop_left > 0) begin
                drop_left--;
            end else if (val_q.size() > 0 && !val_hold && !(rand_stall && $urandom_range(3) == 0)) begin
                bus.val_valid = 1'b1;
                bus.val_data  = val_q[0];
                if (bus.val_ready) begin
                    void'(val_q.pop_front());
                    val_accepted++;
                    if (drop_after != 0 && val_accepted == drop_after) drop_left = 2;
                end
            end
        end
    end

    // Reference: a row of n values is n elements {last, value}, first one marked; n=0 is one {1,0} marker.
    task automatic add_row(input int r, input int n, input int base);
        exp_t e;
        logic [DATA_W-1:0] v;
        nze_q.push_back(NZE_W'(n));
        if (n == 0) begin
            e.el = {1'b1, {DATA_W{1'b0}}};
            e.sb = 1'b1;
            e.ri = ROWS_W'(r);
            exp_q.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            v = (base != 0) ? DATA_W'(base * (k + 1)) : DATA_W'($urandom_range(32'hFF_FFFF, 1));
            val_q.push_back(v);
            e.el = {(k == n - 1), v};
            e.sb = (k == 0);
            e.ri = ROWS_W'(r);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input int n);
        @(negedge clock);
        bus.start    = 1'b1;
        bus.num_rows = ROWS_W'(n);
        @(negedge clock);
        bus.start    = 1'b0;
        bus.num_rows = ROWS_W'($urandom);
    endtask

    task automatic wait_done(input string name, input int d0);
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt != d0) break;
            @(negedge clock);
        end
        check({name, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
        @(negedge clock);
        check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
        check({name, "_pending_elements"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        nze_q.delete();
        val_q.delete();
    endtask

    task automatic run_pass(input string name, input int n);
        int d0;
        d0 = done_cnt;
        do_start(n);
        wait_done(name, d0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_element"}, 64'(bus.element), 64'd0);
        check({name, "_set_bit"}, 64'(bus.set_bit), 64'd0);
        check({name, "_row_index"}, 64'(bus.row_index), 64'd0);
        check({name, "_busy"}, 64'(bus.busy), 64'd0);
        check({name, "_done"}, 64'(bus.done), 64'd0);
        check({name, "_underrun"}, 64'(bus.underrun), 64'd0);
        check({name, "_nze_ready"}, 64'(bus.nze_ready), 64'd0);
        check({name, "_val_ready"}, 64'(bus.val_ready), 64'd0);
    endtask

    initial begin
        int d0;
        int n;
        bus.start    = 1'b0;
        bus.num_rows = '0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Single row, three values, no stalls.
        last_cyc = -1;
        add_row(0, 3, 'h11);
        run_pass("t1", 1);
        check("t1_first_to_last", 64'(last_cyc - first_cyc), 64'd2);
        check("t1_last_to_done", 64'(done_cyc - last_cyc), 64'(DRAIN_CYCLES));
        check("t1_underrun", 64'(bus.underrun), 64'd0);

        // Two rows back to back: minimum bubbles between rows.
        last_cyc = -1;
        gap = -1;
        sb_cnt = 0;
        add_row(0, 2, 0);
        add_row(1, 1, 0);
        run_pass("t2", 2);
        check("t2_bubbles_last_to_set_bit", 64'(gap), 64'(DRAIN_CYCLES + 1));
        check("t2_set_bit_count", 64'(sb_cnt), 64'd2);

        // Empty row.
        saw_val_ready = 0;
        add_row(0, 0, 0);
        run_pass("t3", 1);
        check("t3_val_ready_seen", 64'(saw_val_ready), 64'd0);

        // Two-cycle starvation mid-row.
        val_accepted = 0;
        drop_after = 2;
        add_row(0, 4, 0);
        run_pass("t4", 1);
        drop_after = 0;
        check("t4_underrun", 64'(bus.underrun), 64'd1);
`ifdef SRS_UNDERRUN_CNT_EN
        check("t4_underrun_cnt", 64'(bus.underrun_cnt), 64'd2);
`endif
        repeat (4) @(negedge clock);
        check("t4_underrun_sticky", 64'(bus.underrun), 64'd1);

        // Next clean pass clears the sticky flag.
        add_row(0, 1, 0);
        run_pass("t4b", 1);
        check("t4b_underrun_cleared", 64'(bus.underrun), 64'd0);

        // Reset in the middle of a long row.
        add_row(0, 8, 0);
        add_row(1, 2, 0);
        do_start(2);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() <= 7) break;
            @(negedge clock);
        end
        check("t5_reached_stream", 64'(exp_q.size() <= 7), 64'd1);
        reset = 1'b1;
        exp_q.delete();
        nze_q.delete();
        val_q.delete();
        @(negedge clock);
        check_reset_outputs("t5_reset");
        reset = 1'b0;
        add_row(0, 2, 0);
        add_row(1, 3, 0);
        run_pass("t5_after", 2);

        // Empty pass.
        saw_nze_ready = 0;
        d0 = done_cnt;
        do_start(0);
        check("t6_empty_done", 64'(bus.done), 64'd1);
        check("t6_empty_busy", 64'(bus.busy), 64'd0);
        @(negedge clock);
        check("t6_empty_done_pulse", 64'(done_cnt - d0), 64'd1);
        check("t6_empty_nze_ready_seen", 64'(saw_nze_ready), 64'd0);
`ifdef SRS_UNDERRUN_CNT_EN
        check("t6_empty_cnt_cleared", 64'(bus.underrun_cnt), 64'd0);
`endif

        // Start while busy is ignored: a 3-row restart would stall in FETCH forever.
        val_hold = 1;
        add_row(0, 5, 0);
        d0 = done_cnt;
        do_start(1);
        repeat (3) @(negedge clock);
        check("t6_busy_before_restart", 64'(bus.busy), 64'd1);
        do_start(3);
        val_hold = 0;
        wait_done("t6_ignored_start", d0);

        // Randomized passes with stalls on both inputs.
        rand_stall = 1;
        for (int p = 0; p < 8; p++) begin
            n = $urandom_range(4, 1);
            for (int r = 0; r < n; r++) add_row(r, $urandom_range(6, 0), 0);
            run_pass("rand", n);
        end
        rand_stall = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
